// File: rtl/xgmii_pkg.sv
// Shared XGMII control codes, the Idle column, IFG state encoding and a
// saturating subtract used by the gap counter.
package xgmii_pkg;

  localparam logic [7:0]  XGMII_IDLE  = 8'h07;
  localparam logic [7:0]  XGMII_START = 8'hFB;
  localparam logic [7:0]  XGMII_TERM  = 8'hFD;

  localparam logic [63:0] XGMII_IDLE_COL_D = {8{XGMII_IDLE}};
  localparam logic [7:0]  XGMII_IDLE_COL_C = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_GAP   = 2'd2
  } ifg_state_e;

  // Floors at zero so the gap counter can never wrap.
  function automatic logic [4:0] sat_sub(input logic [4:0] a, input logic [4:0] b);
    return (a > b) ? (a - b) : 5'd0;
  endfunction

endpackage

// File: rtl/xgmii_term_lane.sv
// Finds the lowest lane of a column carrying a Terminate control byte.
module xgmii_term_lane
  import xgmii_pkg::*;
(
  input  logic [63:0] txd_i,
  input  logic [7:0]  txc_i,
  output logic        term_o,
  output logic [2:0]  lane_o
);

  // Scan high to low so the lowest matching lane is the last one written.
  always_comb begin
    term_o = 1'b0;
    lane_o = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (txc_i[k] && (txd_i[8*k +: 8] == XGMII_TERM)) begin
        term_o = 1'b1;
        lane_o = 3'(k);
      end
    end
  end

endmodule

// File: rtl/xgmii_tx_ifg.sv
// XGMII TX inter-frame gap enforcer: stalls a Start that arrives too soon
// after a Terminate and fills the hole with Idle columns.
module xgmii_tx_ifg
  import xgmii_pkg::*;
#(
  parameter logic [4:0] Gap = 5'd12
) (
  input  logic        xgmii_tx_clk,
  input  logic        sys_rst,
  input  logic [63:0] xgmii_txd_i,
  input  logic [7:0]  xgmii_txc_i,
  output logic        tx_ready_o,
  output logic [63:0] xgmii_txd_o,
  output logic [7:0]  xgmii_txc_o,
  output ifg_state_e  dbg_state_o
);

  // Handshake: upstream column is consumed on a rising edge where
  // tx_ready_o is high; while low, upstream holds the same column.

  ifg_state_e  state_q, state_d;
  logic [4:0]  gap_cnt_q, gap_cnt_d;
  logic [63:0] txd_q, txd_d;
  logic [7:0]  txc_q, txc_d;

  logic        is_start, all_idle, stall;
  logic        term_present;
  logic [2:0]  term_lane;
  logic [4:0]  term_gap, gap_minus8;

  xgmii_term_lane u_term_lane (
    .txd_i  (xgmii_txd_i),
    .txc_i  (xgmii_txc_i),
    .term_o (term_present),
    .lane_o (term_lane)
  );

  assign is_start   = xgmii_txc_i[0] && (xgmii_txd_i[7:0] == XGMII_START);
  assign all_idle   = (xgmii_txc_i == XGMII_IDLE_COL_C) && (xgmii_txd_i == XGMII_IDLE_COL_D);
  // Lanes above the Terminate already count as idle bytes of the gap.
  assign term_gap   = sat_sub(Gap, {2'b00, 3'd7 - term_lane});
  assign gap_minus8 = sat_sub(gap_cnt_q, 5'd8);
  assign stall      = (state_q == ST_GAP) && is_start;

  assign tx_ready_o  = !sys_rst && !stall;
  assign xgmii_txd_o = txd_q;
  assign xgmii_txc_o = txc_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    txd_d     = xgmii_txd_i;
    txc_d     = xgmii_txc_i;
    case (state_q)
      ST_IDLE: begin
        if (is_start) state_d = ST_FRAME;
      end
      ST_FRAME: begin
        if (is_start) begin
          state_d = ST_FRAME;
        end else if (term_present) begin
          gap_cnt_d = term_gap;
          state_d   = (term_gap != 5'd0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (is_start) begin
          txd_d     = XGMII_IDLE_COL_D;
          txc_d     = XGMII_IDLE_COL_C;
          gap_cnt_d = gap_minus8;
          if (gap_minus8 == 5'd0) state_d = ST_IDLE;
        end else if (all_idle) begin
          gap_cnt_d = gap_minus8;
          if (gap_minus8 == 5'd0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge xgmii_tx_clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= 5'd0;
      txd_q     <= XGMII_IDLE_COL_D;
      txc_q     <= XGMII_IDLE_COL_C;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      txd_q     <= txd_d;
      txc_q     <= txc_d;
    end
  end

endmodule

// File: tb/tb_xgmii_tx_ifg.sv
// Bench for xgmii_tx_ifg: two instances (Gap=12 and Gap=0) driven with
// directed frame sequences and checked every cycle against a gap model.
module tb_xgmii_tx_ifg;
  import xgmii_pkg::*;

  localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_C  = 8'hFF;
  localparam logic [63:0] START_D = 64'hA1A2A3A4A5A6A7FB;
  localparam logic [7:0]  START_C = 8'h01;
  localparam logic [63:0] DATA_D  = 64'h0102030405060708;
  localparam logic [7:0]  DATA_C  = 8'h00;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] txd_in  [2];
  logic [7:0]  txc_in  [2];
  logic [63:0] txd_out [2];
  logic [7:0]  txc_out [2];
  logic        rdy     [2];
  ifg_state_e  st      [2];

  initial begin
    txd_in[0] = IDLE_D; txc_in[0] = IDLE_C;
    txd_in[1] = IDLE_D; txc_in[1] = IDLE_C;
  end

  xgmii_tx_ifg #(.Gap(5'd12)) dut0 (
    .xgmii_tx_clk (clk),
    .sys_rst      (rst),
    .xgmii_txd_i  (txd_in[0]),
    .xgmii_txc_i  (txc_in[0]),
    .tx_ready_o   (rdy[0]),
    .xgmii_txd_o  (txd_out[0]),
    .xgmii_txc_o  (txc_out[0]),
    .dbg_state_o  (st[0])
  );

  xgmii_tx_ifg #(.Gap(5'd0)) dut1 (
    .xgmii_tx_clk (clk),
    .sys_rst      (rst),
    .xgmii_txd_i  (txd_in[1]),
    .xgmii_txc_i  (txc_in[1]),
    .tx_ready_o   (rdy[1]),
    .xgmii_txd_o  (txd_out[1]),
    .xgmii_txc_o  (txc_out[1]),
    .dbg_state_o  (st[1])
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [71:0] exp_q0[$];
  logic [71:0] exp_q1[$];

  int m_owed  [2] = '{0, 0};
  bit m_frame [2] = '{1'b0, 1'b0};

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gap_of(input int i);
    return (i == 0) ? 12 : 0;
  endfunction

  function automatic bit col_is_start(input logic [63:0] d, input logic [7:0] c);
    return c[0] && (d[7:0] == 8'hFB);
  endfunction

  function automatic bit col_all_idle(input logic [63:0] d, input logic [7:0] c);
    bit r = 1'b1;
    for (int j = 0; j < 8; j++)
      if (!c[j] || d[8*j +: 8] != 8'h07) r = 1'b0;
    return r;
  endfunction

  function automatic int col_term_lane(input logic [63:0] d, input logic [7:0] c);
    for (int j = 0; j < 8; j++)
      if (c[j] && d[8*j +: 8] == 8'hFD) return j;
    return -1;
  endfunction

  // Model: idle bytes still owed after the last frame; a Start arriving
  // while bytes are owed is replaced by a full Idle column (8 bytes).
  always @(negedge clk) begin
    logic [71:0] exp_col, nxt;
    logic [63:0] d;
    logic [7:0]  c;
    logic        exp_rdy;
    int          k, owed;
    for (int i = 0; i < 2; i++) begin
      if (i == 0 && exp_q0.size() > 0) begin
        exp_col = exp_q0.pop_front();
        check("out0", {txc_out[0], txd_out[0]}, exp_col);
      end
      if (i == 1 && exp_q1.size() > 0) begin
        exp_col = exp_q1.pop_front();
        check("out1", {txc_out[1], txd_out[1]}, exp_col);
      end
      d = txd_in[i];
      c = txc_in[i];
      exp_rdy = !rst && !(!m_frame[i] && m_owed[i] > 0 && col_is_start(d, c));
      check((i == 0) ? "ready0" : "ready1", 72'(rdy[i]), 72'(exp_rdy));
      nxt = {c, d};
      if (rst) begin
        nxt = {IDLE_C, IDLE_D};
        m_owed[i]  = 0;
        m_frame[i] = 1'b0;
      end else if (col_is_start(d, c)) begin
        if (!m_frame[i] && m_owed[i] > 0) begin
          nxt = {IDLE_C, IDLE_D};
          m_owed[i] = (m_owed[i] > 8) ? m_owed[i] - 8 : 0;
        end else begin
          m_frame[i] = 1'b1;
        end
      end else if (m_frame[i] && col_term_lane(d, c) >= 0) begin
        k = col_term_lane(d, c);
        owed = gap_of(i) - (7 - k);
        m_owed[i]  = (owed > 0) ? owed : 0;
        m_frame[i] = 1'b0;
      end else if (!m_frame[i] && col_all_idle(d, c)) begin
        m_owed[i] = (m_owed[i] > 8) ? m_owed[i] - 8 : 0;
      end
      if (i == 0) exp_q0.push_back(nxt);
      else        exp_q1.push_back(nxt);
    end
  end

  // ---------------- driver ----------------
  function automatic void term_col(input int k, output logic [63:0] d, output logic [7:0] c);
    for (int j = 0; j < 8; j++) begin
      if (j < k)       begin d[8*j +: 8] = 8'(8'h10 + j); c[j] = 1'b0; end
      else if (j == k) begin d[8*j +: 8] = 8'hFD;         c[j] = 1'b1; end
      else             begin d[8*j +: 8] = 8'h07;         c[j] = 1'b1; end
    end
  endfunction

  // Presents a column and holds it until it is accepted; returns stalls.
  task automatic send(input int i, input logic [63:0] d, input logic [7:0] c, output int stalls);
    #1;
    txd_in[i] = d;
    txc_in[i] = c;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (rdy[i]) begin
        @(posedge clk);
        break;
      end
      stalls++;
      if (stalls > 6) begin
        checks++;
        failures++;
        $display("FAIL send_timeout inst%0d: ready low %0d cycles, required at most 6", i, stalls);
        @(posedge clk);
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic send_term(input int i, input int k);
    logic [63:0] d;
    logic [7:0]  c;
    int s;
    term_col(k, d, c);
    send(i, d, c, s);
  endtask

  task automatic frame_then_start(input int i, input int k, input int exp_owed,
                                  input int exp_stalls, input string name);
    int s;
    send(i, START_D, START_C, s);
    send(i, DATA_D, DATA_C, s);
    send_term(i, k);
    check({name, "_owed"}, 72'(m_owed[i]), 72'(exp_owed));
    send(i, START_D, START_C, s);
    check({name, "_stalls"}, 72'(s), 72'(exp_stalls));
    send(i, DATA_D, DATA_C, s);
    send_term(i, 7);
    send(i, IDLE_D, IDLE_C, s);
    repeat (3) send(i, IDLE_D, IDLE_C, s);
  endtask

  initial begin
    int s;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out0", {txc_out[0], txd_out[0]}, {8'hFF, 64'h0707070707070707});
    check("rst_ready0", 72'(rdy[0]), 72'(1'b0));
    check("rst_state0", 72'(st[0]), 72'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk);

    // Gap=12 instance
    frame_then_start(0, 3, 8, 1, "term3_start");
    frame_then_start(0, 0, 5, 1, "term0_start");
    frame_then_start(0, 7, 12, 2, "term7_start");

    send(0, START_D, START_C, s);
    send(0, DATA_D, DATA_C, s);
    send_term(0, 3);
    send(0, IDLE_D, IDLE_C, s);
    send(0, START_D, START_C, s);
    check("idle_then_start_stalls", 72'(s), 72'(0));
    send(0, DATA_D, DATA_C, s);
    send_term(0, 3);
    check("pre_rst_owed", 72'(m_owed[0]), 72'(8));

    // Reset pulse mid-gap with Start held
    #1;
    txd_in[0] = START_D;
    txc_in[0] = START_C;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midgap_rst_out", {txc_out[0], txd_out[0]}, {8'hFF, 64'h0707070707070707});
    check("midgap_rst_ready", 72'(rdy[0]), 72'(1'b0));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 72'(rdy[0]), 72'(1'b1));
    @(posedge clk);
    #1;
    check("post_rst_start", {txc_out[0], txd_out[0]}, {8'h01, 64'hA1A2A3A4A5A6A7FB});
    send(0, DATA_D, DATA_C, s);
    send_term(0, 7);
    send(0, IDLE_D, IDLE_C, s);

    // Gap=0 instance: back-to-back frames never stall
    for (int n = 0; n < 3; n++) begin
      send(1, START_D, START_C, s);
      check("gap0_stalls", 72'(s), 72'(0));
      send(1, DATA_D, DATA_C, s);
      send_term(1, (n == 2) ? 0 : 7);
      check("gap0_owed", 72'(m_owed[1]), 72'(0));
    end
    send(1, IDLE_D, IDLE_C, s);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
